// File: rtl/ycbcr_rgb_pkg.sv
// Shared types, colour-matrix coefficients and arithmetic helpers for the
// YCbCr444 -> RGB converter.
package ycbcr_rgb_pkg;

  typedef enum logic [1:0] {
    MODE_601S = 2'd0,
    MODE_601F = 2'd1,
    MODE_709S = 2'd2,
    MODE_GREY = 2'd3
  } mode_e;

  // Fraction bits of the master coefficient table
  localparam int COEF_Q = 14;

  typedef struct packed {
    int cy;
    int crr;
    int cbg;
    int crg;
    int cbb;
  } coef_set_t;

  localparam coef_set_t COEF_601S = '{cy: 19071, crr: 26149, cbg: -6406, crg: -13320, cbb: 33063};
  localparam coef_set_t COEF_601F = '{cy: 16384, crr: 22970, cbg: -5636, crg: -11698, cbb: 29032};
  localparam coef_set_t COEF_709S = '{cy: 19071, crr: 29376, cbg: -3494, crg: -8733,  cbb: 34603};

  // Rescale a Q2.14 coefficient to 'frac' fraction bits, rounding half up
  function automatic int scale_coef(input int c_q14, input int frac);
    if (frac >= COEF_Q)
      return c_q14 <<< (frac - COEF_Q);
    return (c_q14 + (1 <<< (COEF_Q - 1 - frac))) >>> (COEF_Q - frac);
  endfunction

  // Clamp a signed value to the unsigned range [0, 2^dw-1]
  function automatic logic [15:0] clip(input logic signed [31:0] v, input int dw);
    int mx;
    mx = (1 << dw) - 1;
    if (v < 0)
      return '0;
    if (v > mx)
      return 16'(mx);
    return v[15:0];
  endfunction

  // True when clip() would alter the value
  function automatic logic clip_flag(input logic signed [31:0] v, input int dw);
    int mx;
    mx = (1 << dw) - 1;
    return (v < 0) || (v > mx);
  endfunction

endpackage

// File: rtl/image_ycbcr_rgb_cfg_mac3.sv
// One output channel: three signed products, rounded sum, clip to DW bits.
// Three register stages: products, rounded sum, clipped result + clip flag.
module ycc_mac3
  import ycbcr_rgb_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [FRAC+2:0] coef0,
  input  logic signed [FRAC+2:0] coef1,
  input  logic signed [FRAC+2:0] coef2,
  input  logic signed [DW+1:0]   diff0,
  input  logic signed [DW+1:0]   diff1,
  input  logic signed [DW+1:0]   diff2,
  output logic [DW-1:0]          pix_out,
  output logic                   clip_out
);

  localparam int PW    = DW + FRAC + 5;
  localparam int ACC_W = DW + FRAC + 6;
  localparam int SW    = DW + 6;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);

  logic signed [PW-1:0]    prod0, prod1, prod2;
  logic signed [ACC_W-1:0] acc;
  logic signed [SW-1:0]    sum_q;

  // Stage 1: register the three products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod0 <= '0;
      prod1 <= '0;
      prod2 <= '0;
    end else begin
      prod0 <= PW'(coef0) * PW'(diff0);
      prod1 <= PW'(coef1) * PW'(diff1);
      prod2 <= PW'(coef2) * PW'(diff2);
    end
  end

  // Sum of products plus half an LSB for round-to-nearest
  always_comb begin
    acc = ACC_W'(prod0) + ACC_W'(prod1) + ACC_W'(prod2) + RND;
  end

  // Stage 2: drop the fraction bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_q <= '0;
    else
      sum_q <= SW'(acc >>> FRAC);
  end

  // Stage 3: clamp to pixel range and flag any clamping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out  <= '0;
      clip_out <= 1'b0;
    end else begin
      pix_out  <= DW'(clip(32'(sum_q), DW));
      clip_out <= clip_flag(32'(sum_q), DW);
    end
  end

endmodule

// File: rtl/image_ycbcr_rgb_cfg.sv
// YCbCr444 -> RGB converter with frame-synchronous matrix selection,
// 3-clk fixed latency and a per-frame count of clipped pixels.
module image_ycbcr_rgb_cfg
  import ycbcr_rgb_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 10,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cfg_mode,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_Y,
  input  logic [DW-1:0] per_img_Cb,
  input  logic [DW-1:0] per_img_Cr,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [DW-1:0] post_img_red,
  output logic [DW-1:0] post_img_green,
  output logic [DW-1:0] post_img_blue,
  output logic [1:0]    mode_active,
  output logic [CW-1:0] sat_count
);

  localparam int KW = FRAC + 3;
  localparam logic [DW-1:0] YOFF_S = DW'(16) << (DW - 8);
  localparam logic [DW-1:0] COFF   = DW'(1) << (DW - 1);

  localparam logic signed [KW-1:0] K601S_CY  = KW'(scale_coef(COEF_601S.cy,  FRAC));
  localparam logic signed [KW-1:0] K601S_CRR = KW'(scale_coef(COEF_601S.crr, FRAC));
  localparam logic signed [KW-1:0] K601S_CBG = KW'(scale_coef(COEF_601S.cbg, FRAC));
  localparam logic signed [KW-1:0] K601S_CRG = KW'(scale_coef(COEF_601S.crg, FRAC));
  localparam logic signed [KW-1:0] K601S_CBB = KW'(scale_coef(COEF_601S.cbb, FRAC));
  localparam logic signed [KW-1:0] K601F_CY  = KW'(scale_coef(COEF_601F.cy,  FRAC));
  localparam logic signed [KW-1:0] K601F_CRR = KW'(scale_coef(COEF_601F.crr, FRAC));
  localparam logic signed [KW-1:0] K601F_CBG = KW'(scale_coef(COEF_601F.cbg, FRAC));
  localparam logic signed [KW-1:0] K601F_CRG = KW'(scale_coef(COEF_601F.crg, FRAC));
  localparam logic signed [KW-1:0] K601F_CBB = KW'(scale_coef(COEF_601F.cbb, FRAC));
  localparam logic signed [KW-1:0] K709S_CY  = KW'(scale_coef(COEF_709S.cy,  FRAC));
  localparam logic signed [KW-1:0] K709S_CRR = KW'(scale_coef(COEF_709S.crr, FRAC));
  localparam logic signed [KW-1:0] K709S_CBG = KW'(scale_coef(COEF_709S.cbg, FRAC));
  localparam logic signed [KW-1:0] K709S_CRG = KW'(scale_coef(COEF_709S.crg, FRAC));
  localparam logic signed [KW-1:0] K709S_CBB = KW'(scale_coef(COEF_709S.cbb, FRAC));

  logic                  vsync_q;
  logic                  vsync_rise;
  mode_e                 mode_active_q;
  logic signed [KW-1:0]  k_cy, k_crr, k_cbg, k_crg, k_cbb;
  logic [DW-1:0]         yoff;
  logic signed [DW+1:0]  d_y, d_cb, d_cr;
  logic [DW-1:0]         r_pix, g_pix, b_pix;
  logic                  r_clip, g_clip, b_clip;
  logic [2:0]            vs_sr, hr_sr, ck_sr;
  logic [DW-1:0]         y_d1, y_d2, y_d3;
  mode_e                 mode_d1, mode_d2, mode_d3;
  logic                  grey3;
  logic                  post_vs_q;
  logic                  post_vs_rise;
  logic                  clip_hit;
  logic [CW-1:0]         sat_cnt;
  logic [CW-1:0]         sat_count_q;

  assign vsync_rise = per_frame_vsync & ~vsync_q;

  // Latch the requested matrix once per frame, on the input vsync rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      mode_active_q <= MODE_601S;
    end else begin
      vsync_q <= per_frame_vsync;
      if (vsync_rise)
        mode_active_q <= mode_e'(cfg_mode);
    end
  end

  // Coefficient and luma-offset selection for the pixel entering S1
  always_comb begin
    k_cy  = '0;
    k_crr = '0;
    k_cbg = '0;
    k_crg = '0;
    k_cbb = '0;
    yoff  = '0;
    case (mode_active_q)
      MODE_601S: begin
        k_cy = K601S_CY; k_crr = K601S_CRR; k_cbg = K601S_CBG;
        k_crg = K601S_CRG; k_cbb = K601S_CBB; yoff = YOFF_S;
      end
      MODE_601F: begin
        k_cy = K601F_CY; k_crr = K601F_CRR; k_cbg = K601F_CBG;
        k_crg = K601F_CRG; k_cbb = K601F_CBB; yoff = '0;
      end
      MODE_709S: begin
        k_cy = K709S_CY; k_crr = K709S_CRR; k_cbg = K709S_CBG;
        k_crg = K709S_CRG; k_cbb = K709S_CBB; yoff = YOFF_S;
      end
      default: begin
        k_cy = '0; k_crr = '0; k_cbg = '0; k_crg = '0; k_cbb = '0; yoff = '0;
      end
    endcase
  end

  assign d_y  = $signed({2'b00, per_img_Y})  - $signed({2'b00, yoff});
  assign d_cb = $signed({2'b00, per_img_Cb}) - $signed({2'b00, COFF});
  assign d_cr = $signed({2'b00, per_img_Cr}) - $signed({2'b00, COFF});

  ycc_mac3 #(.DW(DW), .FRAC(FRAC)) u_mac_r (
    .clk(clk), .rst_n(rst_n),
    .coef0(k_cy), .coef1('0), .coef2(k_crr),
    .diff0(d_y), .diff1(d_cb), .diff2(d_cr),
    .pix_out(r_pix), .clip_out(r_clip)
  );

  ycc_mac3 #(.DW(DW), .FRAC(FRAC)) u_mac_g (
    .clk(clk), .rst_n(rst_n),
    .coef0(k_cy), .coef1(k_cbg), .coef2(k_crg),
    .diff0(d_y), .diff1(d_cb), .diff2(d_cr),
    .pix_out(g_pix), .clip_out(g_clip)
  );

  ycc_mac3 #(.DW(DW), .FRAC(FRAC)) u_mac_b (
    .clk(clk), .rst_n(rst_n),
    .coef0(k_cy), .coef1(k_cbb), .coef2('0),
    .diff0(d_y), .diff1(d_cb), .diff2(d_cr),
    .pix_out(b_pix), .clip_out(b_clip)
  );

  // Sideband, raw luma and per-pixel mode travel alongside the MAC stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr   <= '0;
      hr_sr   <= '0;
      ck_sr   <= '0;
      y_d1    <= '0;
      y_d2    <= '0;
      y_d3    <= '0;
      mode_d1 <= MODE_601S;
      mode_d2 <= MODE_601S;
      mode_d3 <= MODE_601S;
    end else begin
      vs_sr   <= {vs_sr[1:0], per_frame_vsync};
      hr_sr   <= {hr_sr[1:0], per_frame_href};
      ck_sr   <= {ck_sr[1:0], per_frame_clken};
      y_d1    <= per_img_Y;
      y_d2    <= y_d1;
      y_d3    <= y_d2;
      mode_d1 <= mode_active_q;
      mode_d2 <= mode_d1;
      mode_d3 <= mode_d2;
    end
  end

  assign grey3 = (mode_d3 == MODE_GREY);

  assign post_frame_vsync = vs_sr[2];
  assign post_frame_href  = hr_sr[2];
  assign post_frame_clken = ck_sr[2];
  assign post_img_red     = hr_sr[2] ? (grey3 ? y_d3 : r_pix) : '0;
  assign post_img_green   = hr_sr[2] ? (grey3 ? y_d3 : g_pix) : '0;
  assign post_img_blue    = hr_sr[2] ? (grey3 ? y_d3 : b_pix) : '0;
  assign mode_active      = mode_active_q;
  assign sat_count        = sat_count_q;

  assign post_vs_rise = vs_sr[2] & ~post_vs_q;
  assign clip_hit     = ck_sr[2] & hr_sr[2] & ~grey3 & (r_clip | g_clip | b_clip);

  // Clipped-pixel counter; a hit coinciding with the frame swap opens the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs_q   <= 1'b0;
      sat_cnt     <= '0;
      sat_count_q <= '0;
    end else begin
      post_vs_q <= vs_sr[2];
      if (post_vs_rise) begin
        sat_count_q <= sat_cnt;
        sat_cnt     <= clip_hit ? CW'(1) : '0;
      end else if (clip_hit && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_image_ycbcr_rgb_cfg.sv
// Directed bench for image_ycbcr_rgb_cfg: stimulus pushes hand-computed RGB
// into a queue, a negedge monitor pops and compares as pixels emerge.
module tb_image_ycbcr_rgb_cfg;

  localparam int DW = 8;
  localparam int FRAC = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic          per_frame_vsync, per_frame_href, per_frame_clken;
  logic [DW-1:0] per_img_Y, per_img_Cb, per_img_Cr;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [DW-1:0] post_img_red, post_img_green, post_img_blue;
  logic [1:0]    mode_active;
  logic [CW-1:0] sat_count;

  image_ycbcr_rgb_cfg #(.DW(DW), .FRAC(FRAC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken),
    .per_img_Y(per_img_Y), .per_img_Cb(per_img_Cb), .per_img_Cr(per_img_Cr),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken),
    .post_img_red(post_img_red), .post_img_green(post_img_green),
    .post_img_blue(post_img_blue),
    .mode_active(mode_active), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int r;
    int g;
    int b;
    int due;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] sb_hist [64];
  int         sb_from = 1 << 30;
  int         n_err = 0;
  int         n_chk = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus; expected RGB is queued for qualified pixels
  task automatic step(input logic vs, input logic hr, input logic ck,
                      input int y, input int cb, input int cr,
                      input int er, input int eg, input int eb);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_Y  = y[DW-1:0];
    per_img_Cb = cb[DW-1:0];
    per_img_Cr = cr[DW-1:0];
    sb_hist[cyc % 64] = {vs, hr, ck};
    if (hr && ck)
      exp_q.push_back('{er, eg, eb, cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int y, input int cb, input int cr,
                       input int er, input int eg, input int eb);
    step(1'b0, 1'b1, 1'b1, y, cb, cr, er, eg, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, int'(post_frame_vsync), 0);
    check({tag, "_href"},  int'(post_frame_href), 0);
    check({tag, "_clken"}, int'(post_frame_clken), 0);
    check({tag, "_rgb"},   int'({post_img_red, post_img_green, post_img_blue}), 0);
    check({tag, "_mode"},  int'(mode_active), 0);
    check({tag, "_sat"},   int'(sat_count), 0);
  endtask

  // Monitor: sideband delay, blanking and scoreboard comparison
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc - 3 >= sb_from)
        check("sideband_delay", int'({post_frame_vsync, post_frame_href, post_frame_clken}),
              int'(sb_hist[(cyc - 3) % 64]));
      if (!post_frame_href)
        check("rgb_blank", int'({post_img_red, post_img_green, post_img_blue}), 0);
      if (post_frame_href && post_frame_clken) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", cyc, e.due);
          check("red",   int'(post_img_red),   e.r);
          check("green", int'(post_img_green), e.g);
          check("blue",  int'(post_img_blue),  e.b);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_mode = 2'd0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_Y = '0;
    per_img_Cb = '0;
    per_img_Cr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    sb_from = cyc;

    // 601 studio: black, white, a saturated colour; one clken=0 pixel
    cfg_mode = 2'd0;
    vsync_pulse();
    check("mode_601s", int'(mode_active), 0);
    pixel(16, 128, 128, 0, 0, 0);
    pixel(235, 128, 128, 255, 255, 255);
    pixel(128, 128, 180, 213, 88, 130);
    step(1'b0, 1'b1, 1'b0, 200, 50, 50, 0, 0, 0);
    idle(6);

    // 601 full range mid grey
    cfg_mode = 2'd1;
    vsync_pulse();
    check("mode_601f", int'(mode_active), 1);
    check("sat_no_clip", int'(sat_count), 0);
    pixel(128, 128, 128, 128, 128, 128);
    idle(4);

    // Grey bypass, including values that clip in matrix modes
    cfg_mode = 2'd3;
    vsync_pulse();
    check("mode_grey", int'(mode_active), 3);
    pixel(77, 10, 200, 77, 77, 77);
    pixel(255, 255, 255, 255, 255, 255);
    pixel(0, 128, 128, 0, 0, 0);
    idle(4);

    // Clipping frame: 10 high clips + 5 low clips
    cfg_mode = 2'd0;
    vsync_pulse();
    check("mode_back_601s", int'(mode_active), 0);
    check("sat_grey_noclip", int'(sat_count), 0);
    for (int i = 0; i < 10; i++) pixel(255, 128, 255, 255, 175, 255);
    for (int i = 0; i < 5; i++)  pixel(0, 128, 128, 0, 0, 0);
    idle(4);

    // Mid-frame mode request is held off; href=0 blanks the data
    vsync_pulse();
    check("sat_count_15", int'(sat_count), 15);
    pixel(128, 128, 180, 213, 88, 130);
    cfg_mode = 2'd2;
    idle(2);
    check("mode_hold_midframe", int'(mode_active), 0);
    pixel(128, 128, 180, 213, 88, 130);
    step(1'b0, 1'b0, 1'b1, 200, 90, 60, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 150, 20, 240, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 99, 99, 99, 0, 0, 0);
    check("href0_red",   int'(post_img_red), 0);
    check("href0_green", int'(post_img_green), 0);
    check("href0_blue",  int'(post_img_blue), 0);
    check("href0_clken", int'(post_frame_clken), 1);
    idle(4);

    // Next vsync rise switches to 709 studio on the following clock
    check("mode_before_rise", int'(mode_active), 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    check("mode_after_rise", int'(mode_active), 2);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    idle(4);
    pixel(128, 128, 180, 224, 103, 130);
    pixel(0, 128, 128, 0, 0, 0);
    idle(4);

    // New frame, then reset while pixels are in flight
    vsync_pulse();
    check("sat_count_1", int'(sat_count), 1);
    check("mode_709s", int'(mode_active), 2);
    pixel(128, 128, 128, 130, 130, 130);
    pixel(128, 128, 128, 130, 130, 130);
    pixel(128, 128, 128, 130, 130, 130);
    check("pre_reset_href", int'(post_frame_href), 1);
    rst_n = 1'b0;
    sb_from = 1 << 30;
    exp_q.delete();
    #1;
    check_all_zero("async_reset");
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_from = cyc;
    pixel(128, 128, 180, 213, 88, 130);
    check("mode_after_reset", int'(mode_active), 0);
    idle(6);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
